if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage pipeline.
- Holds the PC, drives the instruction-memory address, and captures PC/instruction into IF/ID.
- Honours the hazard unit's PCWrite, IF_ID_Write and IF_Flush, and the ID-stage branch redirect (PCSrc/BranchTarget).
- Sits directly upstream of decode and the hazard detection unit.

Parameters:
- XLEN, 32, datapath/PC width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction inserted into IF/ID on flush or reset (addi x0,x0,0).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- PCWrite  input  1  from hazard unit; 0 holds the PC (stall).
- IF_ID_Write  input  1  from hazard unit; 0 holds the IF/ID register (stall).
- IF_Flush  input  1  from hazard unit; 1 replaces the IF/ID contents with a bubble.
- PCSrc  input  1  branch taken, resolved in ID; 1 selects BranchTarget as next PC.
- BranchTarget  input  XLEN  redirect address from ID.
- imem_addr  output  XLEN  instruction memory address; equals the current PC; memory read is combinational.
- imem_rdata  input  XLEN  instruction word at imem_addr, same cycle.
- IF_ID_PC  output  XLEN  PC of the instruction held in IF/ID.
- IF_ID_Instr  output  XLEN  instruction held in IF/ID.
- IF_ID_Valid  output  1  1 = IF/ID holds a real fetched instruction; 0 = bubble.
- MisalignErr  output  1  sticky; set when a taken redirect target has bits [1:0] != 0.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - PC=RESET_PC, IF_ID_PC=0, IF_ID_Instr=NOP_INSTR, IF_ID_Valid=0, MisalignErr=0.
  - Reset overrides every other input.
  - Reset asserted mid-stall or mid-flush discards the pending operation; fetch resumes at RESET_PC in the first cycle after rst_n=1.
- imem_addr = PC, combinational from the PC register.
- PC update, one per edge:
  - PCWrite=0: PC holds. PCSrc is ignored, because a stalled branch is not yet valid.
  - PCWrite=1 and PCSrc=1: PC = BranchTarget with bits [1:0] forced to 0.
  - PCWrite=1 and PCSrc=0: PC = PC+4, mod 2^XLEN. 32'hFFFF_FFFC wraps to 0 with no flag.
- MisalignErr:
  - Set to 1 on an edge where PCWrite=1, PCSrc=1 and BranchTarget[1:0] != 0.
  - Stays 1 until reset.
- IF/ID update, in priority order:
  1. IF_Flush=1: IF_ID_Instr=NOP_INSTR, IF_ID_Valid=0, IF_ID_PC=PC. Flush wins over IF_ID_Write=0.
  2. IF_ID_Write=0: all IF/ID outputs hold.
  3. Otherwise: IF_ID_PC=PC, IF_ID_Instr=imem_rdata, IF_ID_Valid=1.
- Latency:
  - A fetched instruction appears on the IF/ID outputs one cycle after its PC is on imem_addr.
  - A taken branch costs one bubble, because the hazard unit pulses IF_Flush in the same cycle as PCSrc.
- Simultaneous events:
  - IF_Flush=1, PCWrite=1, PCSrc=1: redirect and flush occur on the same edge. The next cycle fetches BranchTarget and IF/ID holds the bubble.
  - IF_Flush=1 with PCWrite=0: the bubble is inserted and the PC holds.
  - PCWrite and IF_ID_Write are independent; mismatched values are legal and follow the rules above.
- First cycle after reset: IF_ID_Valid=0; the instruction at RESET_PC enters IF/ID on the following edge.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds three outputs:
  - stall_cnt[31:0]: counts edges with PCWrite=0.
  - flush_cnt[31:0]: counts edges with IF_Flush=1.
  - fetch_cnt[31:0]: counts edges where IF/ID loaded a valid instruction.
  - All three clear on reset and saturate at 32'hFFFF_FFFF.
- When undefined: the ports and logic are absent and core behaviour is identical.

Test Plan:
- Reset then free-run with imem_rdata = {PC[31:2]}, PCWrite=1, IF_ID_Write=1 -> imem_addr steps 0,4,8; IF_ID_PC lags by one cycle; IF_ID_Valid=0 for cycle 1, then 1.
- Load-use stall: PCWrite=0, IF_ID_Write=0 for one cycle at PC=8 -> PC holds at 8; IF_ID_PC/IF_ID_Instr hold at 4's values; normal advance resumes to 12.
- Branch: PCSrc=1, BranchTarget=0x40, IF_Flush=1 at PC=0x10 -> next imem_addr=0x40; IF_ID_Instr=0x00000013, IF_ID_Valid=0; next cycle IF_ID_PC=0x40, Valid=1.
- Flush during stall: IF_Flush=1, IF_ID_Write=0, PCWrite=0 -> bubble inserted; PC unchanged; PCSrc=1 in the same cycle is ignored.
- Misaligned target: PCSrc=1, BranchTarget=0x42 -> PC=0x40; MisalignErr=1 and stays 1 through 10 cycles; clears only on rst_n=0.
- Wrap and reset: PC forced via branch to 0xFFFFFFFC -> next PC=0; assert rst_n=0 mid-stall -> outputs take their reset values on that edge. With FETCH_PERF_EN defined, counters read 0 after reset.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register, imem address, IF/ID pipeline register with stall/flush/redirect.
// Define FETCH_PERF_EN to add saturating stall/flush/fetch event counters.
module if_fetch_stage #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [XLEN-1:0]  NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PCWrite,
  input  logic            IF_ID_Write,
  input  logic            IF_Flush,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] BranchTarget,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] IF_ID_PC,
  output logic [XLEN-1:0] IF_ID_Instr,
  output logic            IF_ID_Valid,
  output logic            MisalignErr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt,
  output logic [31:0]     fetch_cnt
`endif
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } ifIdReg_t;

  logic [XLEN-1:0] pcReg;
  logic [XLEN-1:0] pcNext;
  ifIdReg_t        ifIdReg;
  ifIdReg_t        ifIdNext;
  logic            redirectMisaligned;

  assign imem_addr = pcReg;

  // A stalled PC also ignores PCSrc: the branch in ID is not yet resolved.
  always_comb begin
    pcNext = pcReg;
    if (PCWrite) begin
      if (PCSrc) pcNext = {BranchTarget[XLEN-1:2], 2'b00};
      else       pcNext = pcReg + XLEN'(4);
    end
  end

  assign redirectMisaligned = PCWrite && PCSrc && (BranchTarget[1:0] != 2'b00);

  always_comb begin
    ifIdNext = ifIdReg;
    if (IF_Flush) begin
      ifIdNext.pc    = pcReg;
      ifIdNext.instr = NOP_INSTR;
      ifIdNext.valid = 1'b0;
    end else if (IF_ID_Write) begin
      ifIdNext.pc    = pcReg;
      ifIdNext.instr = imem_rdata;
      ifIdNext.valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcReg         <= RESET_PC;
      ifIdReg.pc    <= '0;
      ifIdReg.instr <= NOP_INSTR;
      ifIdReg.valid <= 1'b0;
      MisalignErr   <= 1'b0;
    end else begin
      pcReg   <= pcNext;
      ifIdReg <= ifIdNext;
      if (redirectMisaligned) MisalignErr <= 1'b1;
    end
  end

  assign IF_ID_PC    = ifIdReg.pc;
  assign IF_ID_Instr = ifIdReg.instr;
  assign IF_ID_Valid = ifIdReg.valid;

`ifdef FETCH_PERF_EN
  logic fetchEvt;
  assign fetchEvt = !IF_Flush && IF_ID_Write;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      fetch_cnt <= '0;
    end else begin
      if (!PCWrite && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (IF_Flush && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
      if (fetchEvt && fetch_cnt != 32'hFFFF_FFFF) fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
`endif

endmodule
